// File: rtl/cond_exec_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cond_exec_stage
// Conditional-execution logic of an ARM-style pipeline at the E/M boundary.
// Evaluates the E instruction's condition code against the architectural
// flag register, updates the flags when the instruction passes, and
// registers the E-stage result and control into the M stage. Control bits of
// instructions that fail their condition are suppressed, and such
// instructions are counted in a saturating squash counter.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   stall             : hold all state (flags, counter, M register)
//   flush             : insert a bubble into the M register
//   ALUFlags          : {N,Z,C,V} produced by the ALU for the E instruction
//   ALUResultE        : ALU result of the E instruction
//   WriteDataE        : store data of the E instruction
//   CondE, FlagWriteE, RegWriteE, MemWriteE, MemtoRegE, PCSrcE, WA3E
//                     : E-stage control
//   ALUOutM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemtoRegM
//                     : M-stage pipeline register
//   CondExE           : condition pass of the E instruction (combinational)
//   BranchTakenE      : PCSrcE gated by CondExE (combinational)
//   Flags             : architectural {N,Z,C,V}
//   SquashCount       : saturating count of condition-failed instructions
// ---------------------------------------------------------------------------
module cond_exec_stage #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [3:0]      ALUFlags,
  input  logic [BITS-1:0] ALUResultE,
  input  logic [BITS-1:0] WriteDataE,
  input  logic [3:0]      CondE,
  input  logic [1:0]      FlagWriteE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            MemtoRegE,
  input  logic            PCSrcE,
  input  logic [3:0]      WA3E,
  output logic [BITS-1:0] ALUOutM,
  output logic [BITS-1:0] WriteDataM,
  output logic [3:0]      WA3M,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemtoRegM,
  output logic            CondExE,
  output logic            BranchTakenE,
  output logic [3:0]      Flags,
  output logic [15:0]     SquashCount
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic squash;

  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];

  // Condition decode uses the registered flags only, so a flag-setting
  // instruction influences the following instruction one cycle later.
  always_comb begin
    CondExE = 1'b0;
    unique case (CondE)
      4'b0000: CondExE = flag_z;
      4'b0001: CondExE = ~flag_z;
      4'b0010: CondExE = flag_c;
      4'b0011: CondExE = ~flag_c;
      4'b0100: CondExE = flag_n;
      4'b0101: CondExE = ~flag_n;
      4'b0110: CondExE = flag_v;
      4'b0111: CondExE = ~flag_v;
      4'b1000: CondExE = flag_c & ~flag_z;
      4'b1001: CondExE = ~flag_c | flag_z;
      4'b1010: CondExE = (flag_n == flag_v);
      4'b1011: CondExE = (flag_n != flag_v);
      4'b1100: CondExE = ~flag_z & (flag_n == flag_v);
      4'b1101: CondExE = flag_z | (flag_n != flag_v);
      4'b1110: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end

  assign BranchTakenE = PCSrcE & CondExE;

  // Only instructions that would have had a visible effect count as squashed.
  assign squash = ~CondExE & (RegWriteE | MemWriteE | PCSrcE | (|FlagWriteE));

  // Flag register: NZ and CV halves update independently. Flush does not
  // block the update because the E instruction itself still executes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (!stall && CondExE) begin
      if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Squash counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SquashCount <= 16'h0000;
    end else if (!stall && squash && (SquashCount != 16'hFFFF)) begin
      SquashCount <= SquashCount + 16'h0001;
    end
  end

  // M register: data fields always load when not stalled; on flush only the
  // control bits are forced to a bubble since the data is then unused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= 4'b0000;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
    end else if (!stall) begin
      ALUOutM    <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
      if (flush) begin
        RegWriteM <= 1'b0;
        MemWriteM <= 1'b0;
        MemtoRegM <= 1'b0;
      end else begin
        RegWriteM <= RegWriteE & CondExE;
        MemWriteM <= MemWriteE & CondExE;
        MemtoRegM <= MemtoRegE;
      end
    end
  end

endmodule
